// File: rtl/i2c_phase_timer.sv
// I2C bit-phase timer: splits each bit period into PHASES phases of Ticks cycles,
// pulsing Out at every phase end and BitEnd at the end of the last phase.
module i2c_phase_timer #(
  parameter int SIZE   = 8,
  parameter int PHASES = 4,
  localparam int PW    = $clog2(PHASES)
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic [SIZE-1:0] Ticks,
  input  logic            Start,
  input  logic            Stop,
  input  logic            OneShot,
  output logic            Out,
  output logic            BitEnd,
  output logic [PW-1:0]   Phase,
  output logic [SIZE-1:0] OutCount,
  output logic            Busy,
  output logic            Done,
  output logic            ZeroErr
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [PW-1:0] LAST_PHASE = PW'(PHASES - 1);

  logic [1:0]      state;
  logic [SIZE-1:0] ticks_lat;
  logic            oneshot_lat;

  logic [SIZE-1:0] nxt_count;
  logic [PW-1:0]   nxt_phase;
  logic            nxt_out;
  logic            nxt_bit_end;
  logic            nxt_finish;

  function automatic logic [SIZE-1:0] reload(input logic [SIZE-1:0] t);
    reload = (t == '0) ? '0 : t - 1'b1;
  endfunction

  // One counting step; also applied on the LOAD->RUN edge so the first Out lands Ticks edges after release.
  always_comb begin
    nxt_count   = OutCount;
    nxt_phase   = Phase;
    nxt_out     = 1'b0;
    nxt_bit_end = 1'b0;
    nxt_finish  = 1'b0;
    if (!Stop) begin
      if (OutCount != '0) begin
        nxt_count = OutCount - 1'b1;
      end else begin
        nxt_out   = 1'b1;
        nxt_count = reload(ticks_lat);
        if (Phase == LAST_PHASE) begin
          nxt_bit_end = 1'b1;
          nxt_phase   = '0;
          if (oneshot_lat) begin
            nxt_finish = 1'b1;
            nxt_count  = '0;
          end
        end else begin
          nxt_phase = Phase + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= IDLE;
      ticks_lat   <= '0;
      oneshot_lat <= 1'b0;
      Out         <= 1'b0;
      BitEnd      <= 1'b0;
      Phase       <= '0;
      OutCount    <= '0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      ZeroErr     <= 1'b0;
    end else if (Start) begin
      state       <= LOAD;
      ticks_lat   <= Ticks;
      oneshot_lat <= OneShot;
      OutCount    <= reload(Ticks);
      Phase       <= '0;
      Out         <= 1'b0;
      BitEnd      <= 1'b0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      ZeroErr     <= 1'b0;
    end else begin
      case (state)
        LOAD, RUN: begin
          if (state == LOAD && ticks_lat == '0) begin
            state   <= IDLE;
            ZeroErr <= 1'b1;
          end else begin
            Out      <= nxt_out;
            BitEnd   <= nxt_bit_end;
            Phase    <= nxt_phase;
            OutCount <= nxt_count;
            if (nxt_finish) begin
              state <= DONE;
              Busy  <= 1'b0;
              Done  <= 1'b1;
            end else begin
              state <= RUN;
              Busy  <= 1'b1;
            end
          end
        end
        default: begin
          // IDLE/DONE keep their status; pulses never persist beyond one cycle.
          Out    <= 1'b0;
          BitEnd <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_phase_timer.sv
// Directed bench for i2c_phase_timer with hand-computed expectations.
`timescale 1ns/1ps
module tb_i2c_phase_timer;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [7:0] Ticks;
  logic       Start, Stop, OneShot;
  logic       Out, BitEnd, Busy, Done, ZeroErr;
  logic [1:0] Phase;
  logic [7:0] OutCount;

  int total = 0;
  int fails = 0;

  i2c_phase_timer #(.SIZE(8), .PHASES(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Ticks(Ticks), .Start(Start), .Stop(Stop),
    .OneShot(OneShot), .Out(Out), .BitEnd(BitEnd), .Phase(Phase),
    .OutCount(OutCount), .Busy(Busy), .Done(Done), .ZeroErr(ZeroErr)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  // Returns the number of edges until Out is seen high (max on timeout).
  task automatic wait_out(input int max, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!Out && n < max);
  endtask

  task automatic start_pulse(input logic [7:0] t, input logic os);
    Ticks = t; OneShot = os; Start = 1'b1;
    cyc();
    Start = 1'b0;
  endtask

  int     n, outs, bends, bend_at;
  longint t0, t1;

  initial begin
    Rst_n = 1'b0; Ticks = 8'd0; Start = 1'b0; Stop = 1'b0; OneShot = 1'b0;
    #12;
    chk("rst_out", Out, 0);
    chk("rst_count", OutCount, 0);
    chk("rst_flags", {Busy, Done, ZeroErr, BitEnd, Phase}, 0);
    Rst_n = 1'b1;
    cyc();

    // Periodic run, Ticks=5; later Ticks changes must not matter
    start_pulse(8'd5, 1'b0);
    chk("t1_load_count", OutCount, 4);
    Ticks = 8'd9;
    wait_out(40, n);
    chk("t1_first_gap", n, 5);
    chk("t1_busy", Busy, 1);
    chk("t1_phase1", Phase, 1);
    chk("t1_bitend0", BitEnd, 0);
    wait_out(40, n); chk("t1_gap2", n, 5); chk("t1_phase2", Phase, 2);
    wait_out(40, n); chk("t1_gap3", n, 5); chk("t1_phase3", Phase, 3);
    wait_out(40, n); chk("t1_gap4", n, 5); chk("t1_phase0", Phase, 0);
    chk("t1_bitend", BitEnd, 1);
    cyc();
    chk("t1_pulse_len", {Out, BitEnd}, 0);

    // Stop stretches one phase by two cycles
    start_pulse(8'd8, 1'b0);
    wait_out(40, n);
    chk("t2_first_gap", n, 8);
    t0 = $time;
    cyc(); cyc(); cyc();
    chk("t2_count_at_stop", OutCount, 4);
    Stop = 1'b1;
    cyc(); cyc();
    chk("t2_frozen", OutCount, 4);
    chk("t2_frozen_phase", Phase, 1);
    Stop = 1'b0;
    wait_out(40, n);
    t1 = $time;
    chk("t2_stretched_ns", 32'(t1 - t0), 100);
    wait_out(40, n);
    chk("t2_next_gap", n, 8);

    // Zero limit
    start_pulse(8'd0, 1'b0);
    cyc();
    chk("t3_zeroerr", ZeroErr, 1);
    chk("t3_busy", Busy, 0);
    outs = 0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (Out) outs++;
    end
    chk("t3_no_out", outs, 0);
    chk("t3_zeroerr_held", ZeroErr, 1);
    $display("zero-limit: Ticks==0 run request reported on ZeroErr, no pulses produced");

    // One-shot, Ticks=3
    start_pulse(8'd3, 1'b1);
    outs = 0; bends = 0; bend_at = 0;
    for (int i = 1; i <= 25; i++) begin
      cyc();
      if (Out) outs++;
      if (BitEnd) begin bends++; bend_at = i; end
    end
    chk("t4_outs", outs, 4);
    chk("t4_bitends", bends, 1);
    chk("t4_bitend_cycle", bend_at, 12);
    chk("t4_done", Done, 1);
    chk("t4_busy", Busy, 0);
    chk("t4_phase", Phase, 0);

    // Restart mid-run with Stop high
    start_pulse(8'd6, 1'b0);
    wait_out(40, n); wait_out(40, n);
    chk("t5_phase2", Phase, 2);
    cyc(); cyc();
    Start = 1'b1; Stop = 1'b1;
    cyc();
    chk("t5_reload", OutCount, 5);
    chk("t5_phase", Phase, 0);
    cyc();
    chk("t5_held_out", {Out, Busy}, 0);
    chk("t5_held_count", OutCount, 5);
    Start = 1'b0; Stop = 1'b0;
    wait_out(40, n);
    chk("t5_restart_gap", n, 6);
    chk("t5_restart_phase", Phase, 1);

    // Ticks=1: Out every RUN cycle
    start_pulse(8'd1, 1'b0);
    cyc();
    chk("t1tick_out_a", {Out, Phase}, {1'b1, 2'd1});
    cyc();
    chk("t1tick_out_b", {Out, Phase}, {1'b1, 2'd2});

    // Async reset mid-run, then long phase
    start_pulse(8'd7, 1'b0);
    cyc(); cyc(); cyc();
    #2 Rst_n = 1'b0;
    #1;
    chk("t6_async_outs", {Out, BitEnd, Phase, Busy, Done, ZeroErr}, 0);
    chk("t6_async_count", OutCount, 0);
    #1 Rst_n = 1'b1;
    cyc();
    start_pulse(8'd255, 1'b0);
    wait_out(300, n);
    chk("t6_gap255_first", n, 255);
    wait_out(300, n);
    chk("t6_gap255", n, 255);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
